packer_rr_scheduler: RTL

//  Shares one IN_WIDTH->OUT_WIDTH packer between N_CH requesting channels, round-robin.

---
 rtl/packer_rr_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/packer_rr_scheduler.sv
// Round-robin front end for a shared IN_WIDTH->OUT_WIDTH packer. Each grant lasts exactly
// BEATS accepted beats, so every packed word contains bits from a single channel.
module packer_rr_scheduler #(
  parameter int N_CH      = 4,
  parameter int IN_WIDTH  = 7,
  parameter int OUT_WIDTH = 9,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*IN_WIDTH-1:0] ch_data,
  output logic [N_CH-1:0]          ch_ready,
  output logic [IN_WIDTH-1:0]      pk_in_data,
  output logic                     pk_in_valid,
  output logic [CW-1:0]            pk_chan,
  output logic                     burst_done,
  output logic                     busy
);

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Beats needed for the packer fill point to come back to zero.
  localparam int BEATS = OUT_WIDTH / gcd(IN_WIDTH, OUT_WIDTH);
  localparam int BCW   = $clog2(BEATS + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CW-1:0]  LAST_CH   = CW'(N_CH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      last_ptr_q, last_ptr_d;
  logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
  logic               done_q, done_d;

  logic [IN_WIDTH-1:0] ch_beat [N_CH];
  logic [N_CH-1:0]     req;
  logic                found;
  logic [CW-1:0]       pick;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_beat[gi] = ch_data[gi*IN_WIDTH +: IN_WIDTH];
  end

  assign req = ch_valid & ch_enable;

  // Scan starting one past the last served channel, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 1; off <= N_CH; off++) begin
      int idx;
      idx = (int'(last_ptr_q) + off) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ptr_d  = last_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    ch_ready    = '0;
    pk_in_valid = 1'b0;
    pk_in_data  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        ch_ready[grant_q] = 1'b1;
        pk_in_valid       = ch_valid[grant_q];
        pk_in_data        = ch_beat[grant_q];
        if (ch_valid[grant_q]) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            last_ptr_d = grant_q;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= LAST_CH;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
    end
  end

  assign busy       = (state_q == BURST);
  assign pk_chan    = busy ? grant_q : '0;
  assign burst_done = done_q;

endmodule
